// File: rtl/jc_pkg.sv
// Shared types and Johnson-code helpers for the johnson_decoder block.
// Helpers take the live code width so one package serves any WIDTH up to JC_MAX_W.
package jc_pkg;

  typedef enum logic [1:0] {
    UNLOCK  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } jc_state_e;

  localparam logic [7:0]   ERR_CNT_MAX = 8'd255;
  localparam int unsigned  JC_MAX_W    = 32;

  typedef logic [JC_MAX_W-1:0] jc_code_t;

  // Mask with the low n bits set.
  function automatic jc_code_t jc_ones(input int unsigned n);
    jc_code_t r;
    r = '0;
    for (int unsigned i = 0; i < JC_MAX_W; i++) begin
      r[i] = (i < n);
    end
    return r;
  endfunction

  function automatic int unsigned jc_popcount(input jc_code_t code, input int unsigned w);
    int unsigned p;
    p = 0;
    for (int unsigned i = 0; i < JC_MAX_W; i++) begin
      if (i < w && code[i]) p = p + 1;
    end
    return p;
  endfunction

  function automatic logic jc_msb(input jc_code_t code, input int unsigned w);
    return |(code & jc_ones(w) & ~jc_ones(w - 1));
  endfunction

  // A code is legal when it equals the unique Johnson pattern with its own popcount.
  function automatic logic jc_is_legal(input jc_code_t code, input int unsigned w);
    int unsigned p;
    jc_code_t    expect_code;
    p = jc_popcount(code, w);
    if (jc_msb(code, w)) expect_code = jc_ones(w) & ~jc_ones(w - p);
    else                 expect_code = jc_ones(p);
    return (code & jc_ones(w)) == expect_code;
  endfunction

  function automatic int unsigned jc_to_idx(input jc_code_t code, input int unsigned w);
    int unsigned p;
    p = jc_popcount(code, w);
    if (jc_msb(code, w)) return 2 * w - p;
    return p;
  endfunction

endpackage

// File: rtl/jc_decode_comb.sv
// Combinational map from a Johnson code to {legal, index}.
module jc_decode_comb
  import jc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] jc_in,
  output logic             legal,
  output logic [IW-1:0]    idx
);

  jc_code_t code;

  always_comb begin
    code  = jc_code_t'(jc_in);
    legal = jc_is_legal(code, WIDTH);
    idx   = IW'(jc_to_idx(code, WIDTH));
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter bus decoder and health monitor: index decode, sequence
// checking, lock tracking and a saturating error counter.
module johnson_decoder
  import jc_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned IW     = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] jc_in,
  input  logic             clr_err,
  output logic [IW-1:0]    idx_out,
  output logic             out_valid,
  output logic             illegal,
  output logic             step_err,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam logic [IW-1:0] IDX_LAST = IW'(2 * WIDTH - 1);
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_N);

  logic          legal;
  logic [IW-1:0] idx;
  logic [IW-1:0] prev_idx;
  logic [IW-1:0] prev_next;
  logic          has_prev;
  logic          step_bad;
  logic          good;
  logic          err_event;
  logic [3:0]    good_cnt;
  logic [3:0]    good_next;
  jc_state_e     state;

  jc_decode_comb #(.WIDTH(WIDTH), .IW(IW)) u_dec (
    .jc_in (jc_in),
    .legal (legal),
    .idx   (idx)
  );

  always_comb begin
    prev_next = (prev_idx == IDX_LAST) ? '0 : prev_idx + 1'b1;
    step_bad  = legal && has_prev && (idx != prev_idx) && (idx != prev_next);
    good      = legal && !step_bad;
    err_event = in_valid && (!legal || step_bad);
    good_next = good_cnt + 4'd1;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_out   <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
      prev_idx  <= '0;
      has_prev  <= 1'b0;
      good_cnt  <= '0;
      state     <= UNLOCK;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      step_err  <= 1'b0;

      if (in_valid) begin
        if (legal) begin
          // A mis-stepped sample still becomes the new reference so the decoder re-syncs.
          idx_out   <= idx;
          prev_idx  <= idx;
          has_prev  <= 1'b1;
          out_valid <= 1'b1;
          step_err  <= step_bad;
        end else begin
          illegal  <= 1'b1;
          has_prev <= 1'b0;
        end

        unique case (state)
          UNLOCK: begin
            if (legal) begin
              good_cnt <= 4'd1;
              state    <= (LOCK_N == 1) ? LOCKED : LOCKING;
            end
          end
          LOCKING: begin
            if (good) begin
              good_cnt <= good_next;
              if (good_next >= LOCK_TGT) state <= LOCKED;
            end else begin
              good_cnt <= '0;
              state    <= UNLOCK;
            end
          end
          LOCKED: begin
            if (!good) begin
              good_cnt <= '0;
              state    <= UNLOCK;
            end
          end
          default: begin
            good_cnt <= '0;
            state    <= UNLOCK;
          end
        endcase
      end

      // Clearing in the same cycle as an error leaves that error counted.
      if (clr_err)                             err_cnt <= err_event ? 8'd1 : 8'd0;
      else if (err_event && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
    end
  end

  a_valid_excl: assert property (@(posedge clk) !(illegal && out_valid));
  a_step_impl:  assert property (@(posedge clk) step_err |-> out_valid);

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboarded random/directed bench for johnson_decoder against a table-driven model.
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int LN = 3;
  localparam int NS = 2 * W;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic [W-1:0] jc_in;
  logic         clr_err;
  logic [2:0]   idx_out;
  logic         out_valid;
  logic         illegal;
  logic         step_err;
  logic         locked;
  logic [7:0]   err_cnt;

  johnson_decoder #(.WIDTH(W), .LOCK_N(LN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .jc_in     (jc_in),
    .clr_err   (clr_err),
    .idx_out   (idx_out),
    .out_valid (out_valid),
    .illegal   (illegal),
    .step_err  (step_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx; int ov; int il; int se; int lk; int ec;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: lock phase 0=unlocked, 1=acquiring, 2=locked.
  int m_idx = 0, m_prev = 0, m_has = 0, m_phase = 0, m_good = 0, m_ec = 0;
  int cur_k = 0;

  function automatic int code_of(input int k);
    if (k <= W) return (1 << k) - 1;
    return ((1 << W) - 1) ^ ((1 << (k - W)) - 1);
  endfunction

  function automatic int find_k(input int code);
    for (int k = 0; k < NS; k++) if (code_of(k) == code) return k;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [W-1:0] c, input logic clr);
    exp_t e;
    int k, ov, il, se, bad;
    ov = 0; il = 0; se = 0;
    if (!r) begin
      m_idx = 0; m_prev = 0; m_has = 0; m_phase = 0; m_good = 0; m_ec = 0;
    end else begin
      k = find_k(int'(c));
      if (v) begin
        if (k >= 0) begin
          ov = 1;
          se = (m_has != 0 && k != m_prev && k != (m_prev + 1) % NS) ? 1 : 0;
          m_idx = k; m_prev = k; m_has = 1;
        end else begin
          il = 1; m_has = 0;
        end
        bad = (k < 0 || se != 0) ? 1 : 0;
        if (m_phase == 0) begin
          if (k >= 0) begin m_good = 1; m_phase = (LN == 1) ? 2 : 1; end
        end else if (bad != 0) begin
          m_phase = 0; m_good = 0;
        end else if (m_phase == 1) begin
          m_good++;
          if (m_good >= LN) m_phase = 2;
        end
      end
      if (clr) m_ec = (il != 0 || se != 0) ? 1 : 0;
      else if ((il != 0 || se != 0) && m_ec < 255) m_ec++;
    end
    e.idx = m_idx; e.ov = ov; e.il = il; e.se = se;
    e.lk = (m_phase == 2) ? 1 : 0; e.ec = m_ec;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] c, input logic clr);
    rstn = r; in_valid = v; jc_in = c; clr_err = clr;
    @(posedge clk);
    model_step(r, v, c, clr);
    #1;
  endtask

  task automatic send_k(input int k);
    cur_k = k;
    drive(1'b1, 1'b1, W'(code_of(k)), 1'b0);
  endtask

  task automatic send_code(input logic [W-1:0] c);
    drive(1'b1, 1'b1, c, 1'b0);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, W'($urandom), 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("idx_out",   int'(idx_out),   e.idx);
      chk("out_valid", int'(out_valid), e.ov);
      chk("illegal",   int'(illegal),   e.il);
      chk("step_err",  int'(step_err),  e.se);
      chk("locked",    int'(locked),    e.lk);
      chk("err_cnt",   int'(err_cnt),   e.ec);
    end
  end

  initial begin
    int r, nk;
    rstn = 1'b0; in_valid = 1'b0; jc_in = '0; clr_err = 1'b0;
    drive(1'b0, 1'b1, 4'b0101, 1'b1);
    drive(1'b0, 1'b1, 4'b0011, 1'b0);

    for (int k = 0; k <= NS; k++) send_k(k % NS);

    send_code(4'b0101);
    send_k(2);
    send_k(2);
    send_k(2);
    send_k(5);
    send_k(6);

    send_k(3); idle(); send_k(3); idle(); idle(); send_k(3); idle(); send_k(3);

    for (int i = 0; i < 300; i++) send_code(4'b0101);
    drive(1'b1, 1'b1, 4'b0101, 1'b1);
    drive(1'b1, 1'b0, 4'b0000, 1'b1);

    send_k(0); send_k(1); send_k(2); send_k(3);
    drive(1'b0, 1'b1, W'(code_of(4)), 1'b0);
    send_k(4); send_k(5);

    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 9));
      if      (r < 6) nk = (cur_k + 1) % NS;
      else if (r < 7) nk = cur_k;
      else            nk = int'($urandom_range(0, NS - 1));
      if (r == 9) begin
        drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
              W'($urandom), ($urandom_range(0, 29) == 0));
      end else begin
        cur_k = nk;
        drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
              W'(code_of(nk)), ($urandom_range(0, 29) == 0));
      end
    end

    idle();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receiving-end checker/decoder for a WIDTH-bit Johnson (twisted-ring) counter bus. Samples the Johnson code on each valid cycle and outputs its binary index (0..2*WIDTH-1). Flags illegal codes and out-of-sequence steps, and runs a lock state machine. Sits downstream of the Johnson counter and serves as the decode and health monitor for any block consuming the counter's output.

## Interface
Parameters:
- WIDTH, 4, Johnson code width; the sequence has 2*WIDTH states.
- LOCK_N, 3, number of consecutive good samples needed to declare lock (1..15).
- IW, $clog2(2*WIDTH), index width (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  reset; synchronous, active-low.
- in_valid  in  1  jc_in is sampled only when high.
- jc_in  in  WIDTH  Johnson code from the counter.
- clr_err  in  1  clears err_cnt.
- idx_out  out  IW  decoded index of the last legal sample.
- out_valid  out  1  one-cycle pulse per legal sample.
- illegal  out  1  one-cycle pulse: sampled code is not a Johnson code.
- step_err  out  1  one-cycle pulse: legal code, but not a hold or +1 step from the previous index.
- locked  out  1  high while the FSM is in LOCKED.
- err_cnt  out  8  saturating count of illegal plus step_err events.

## Operation
- Legal code for state k:
  - k in 0..WIDTH: the low k bits are 1 and the rest are 0 (0000, 0001, 0011, 0111, 1111 for WIDTH=4).
  - k in WIDTH+1..2W-1: the low k-WIDTH bits are 0 and the rest are 1 (1110, 1100, 1000).
- Decode: if jc_in[WIDTH-1]==0 then idx = popcount(jc_in); otherwise idx = 2*WIDTH - popcount(jc_in).
- The decoder keeps prev_idx and has_prev. has_prev is cleared by reset and whenever an illegal code is sampled.
- Step check, applied only when has_prev=1 and the code is legal:
  - Good if idx==prev_idx (hold) or idx==(prev_idx+1) mod 2*WIDTH (wrap 2W-1 to 0 is good).
  - Any other legal index raises step_err.
- A step error still updates prev_idx to the new idx and still asserts out_valid. This lets the decoder re-synchronise.
- An illegal code does not update idx_out, does not assert out_valid, and clears has_prev.
- FSM states: UNLOCK, LOCKING, LOCKED; good_cnt is 4 bits.
  - UNLOCK: a legal sample moves to LOCKING with good_cnt=1. If LOCK_N==1, move directly to LOCKED.
  - LOCKING: a good sample increments good_cnt; when good_cnt reaches LOCK_N, move to LOCKED. An illegal sample or step_err goes to UNLOCK with good_cnt=0.
  - LOCKED: an illegal sample or step_err goes to UNLOCK.
  - in_valid=0: the state holds.
- err_cnt:
  - Increments by 1 on illegal or step_err and saturates at 255.
  - clr_err alone sets it to 0.
  - clr_err in the same cycle as an error event sets it to 1.

## Timing
- One-cycle latency: jc_in sampled at edge N appears on idx_out, out_valid, illegal, step_err, locked and err_cnt after edge N.
- illegal, step_err and out_valid are single-cycle pulses. They are 0 in any cycle whose previous edge had in_valid=0.
- illegal and out_valid are mutually exclusive. step_err implies out_valid.
- Reset (rstn=0 at a posedge, at any time including mid-lock): idx_out=0, out_valid=0, illegal=0, step_err=0, locked=0, err_cnt=0, FSM=UNLOCK, has_prev=0, good_cnt=0. in_valid is ignored during that edge.
- The first legal sample after reset or after an illegal code never raises step_err.

## Structure
- Package jc_pkg holds:
  - The FSM state enum (UNLOCK, LOCKING, LOCKED).
  - An ERR_CNT_MAX constant (255).
  - A function jc_is_legal(code).
  - A function jc_to_idx(code).
- One combinational sub-module, jc_decode_comb, maps jc_in to {legal, idx}. The top level holds the registers, step check, FSM and counter.

## Test plan
- Reset, then the full sequence 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with in_valid=1 and LOCK_N=3 -> idx_out = 0,1,...,7,0 each one cycle later; locked rises after the third sample; no errors; err_cnt=0.
- While locked, inject 0101 -> illegal pulse, locked drops, err_cnt=1, idx_out holds its prior value. A following 0011 -> out_valid with idx 2 and no step_err.
- While locked, jump from 0011 (idx 2) to 1110 (idx 5) -> step_err and out_valid, idx_out=5, locked=0, err_cnt increments. A subsequent 1100 (idx 6) is a good step.
- Hold 0111 for 4 samples, with in_valid gaps between them -> no step_err; out_valid pulses only on cycles following in_valid=1.
- Drive 300 illegal samples -> err_cnt saturates at 255. Then clr_err together with an illegal sample -> err_cnt=1. Then clr_err alone -> err_cnt=0.
- Assert rstn=0 for one edge while locked -> all outputs return to their reset values on the next cycle; the next legal sample gives no step_err and the lock count restarts.
